obs_sprite_arbiter: RTL and testbench

//   Shares the single obstacle sprite ROM (obs_rom) between the two obstacle

---
 rtl/dino_pkg.sv | 16 +
 rtl/obs_sprite_arbiter.sv | 150 +++++++++++++++
 tb/tb_obs_sprite_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dino_pkg.sv
// Shared constants and the obstacle-sprite arbiter state type.
package dino_pkg;

  localparam int unsigned CONV_DEF  = 3;
  localparam int unsigned OBS_CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    WAIT0  = 3'd2,
    ISSUE1 = 3'd3,
    WAIT1  = 3'd4,
    COMMIT = 3'd5
  } arb_state_t;

endpackage

// File: rtl/obs_sprite_arbiter.sv
// Time-multiplexes the single obstacle sprite ROM between two renderers within
// one logical pixel and commits both sprite bits (and their OR) atomically.
module obs_sprite_arbiter
  import dino_pkg::*;
#(
  parameter int unsigned CONV    = CONV_DEF,
  parameter int unsigned ROM_LAT = 1,
  parameter int unsigned CNT_W   = OBS_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9-CONV:0]   i_hpos,
  input  logic              i_req0_valid,
  input  logic [CNT_W-1:0]  i_req0_counter,
  input  logic              i_req1_valid,
  input  logic [CNT_W-1:0]  i_req1_counter,
  output logic [CNT_W-1:0]  o_rom_counter,
  input  logic              i_rom_color,
  output logic              o_req0_color,
  output logic              o_req1_color,
  output logic              o_color_obs,
  output logic              o_overrun
);

  localparam int unsigned WAIT_W = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);

  // The whole slot sequence must fit inside one logical pixel.
  if ((2 * (ROM_LAT + 1) + 1) > (1 << CONV)) begin : g_bad_latency
    $error("obs_sprite_arbiter: slot sequence does not fit in one logical pixel");
  end
  if (ROM_LAT < 1) begin : g_bad_rom_lat
    $error("obs_sprite_arbiter: ROM_LAT must be at least 1");
  end

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [9-CONV:0]     r_hpos_q;
  logic                r_snap_v0;
  logic                r_snap_v1;
  logic [CNT_W-1:0]    r_snap_c0;
  logic [CNT_W-1:0]    r_snap_c1;
  logic                r_tmp0;
  logic                r_tmp1;
  logic [WAIT_W-1:0]   r_wait_cnt;

  logic                w_strobe;
  logic                w_wait_last;
  logic                w_load_snap;
  logic                w_wait_clr;
  logic                w_cap0;
  logic                w_cap1;
  logic                w_commit;
  logic                w_overrun;
  logic [CNT_W-1:0]    w_rom_cnt_nxt;

  assign w_strobe    = (i_hpos != r_hpos_q);
  assign w_wait_last = (r_wait_cnt == WAIT_W'(ROM_LAT - 1));

  // Next state; a strobe always wins and restarts the sequence.
  always_comb begin
    w_state_nxt   = r_state;
    w_load_snap   = 1'b0;
    w_wait_clr    = 1'b0;
    w_cap0        = 1'b0;
    w_cap1        = 1'b0;
    w_commit      = 1'b0;
    w_overrun     = 1'b0;
    w_rom_cnt_nxt = o_rom_counter;
    if (w_strobe) begin
      w_state_nxt   = ISSUE0;
      w_load_snap   = 1'b1;
      w_overrun     = (r_state != IDLE);
      w_rom_cnt_nxt = i_req0_valid ? i_req0_counter : '0;
    end else begin
      case (r_state)
        IDLE: ;
        ISSUE0: begin
          w_state_nxt = WAIT0;
          w_wait_clr  = 1'b1;
        end
        WAIT0: begin
          if (w_wait_last) begin
            w_cap0        = 1'b1;
            w_state_nxt   = ISSUE1;
            w_rom_cnt_nxt = r_snap_v1 ? r_snap_c1 : '0;
          end
        end
        ISSUE1: begin
          w_state_nxt = WAIT1;
          w_wait_clr  = 1'b1;
        end
        WAIT1: begin
          if (w_wait_last) begin
            w_cap1      = 1'b1;
            w_state_nxt = COMMIT;
          end
        end
        COMMIT: begin
          w_commit    = 1'b1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_hpos_q      <= '0;
      r_snap_v0     <= 1'b0;
      r_snap_v1     <= 1'b0;
      r_snap_c0     <= '0;
      r_snap_c1     <= '0;
      r_tmp0        <= 1'b0;
      r_tmp1        <= 1'b0;
      r_wait_cnt    <= '0;
      o_rom_counter <= '0;
      o_req0_color  <= 1'b0;
      o_req1_color  <= 1'b0;
      o_color_obs   <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hpos_q      <= i_hpos;
      o_rom_counter <= w_rom_cnt_nxt;
      o_overrun     <= w_overrun;
      if (w_load_snap) begin
        r_snap_v0 <= i_req0_valid;
        r_snap_v1 <= i_req1_valid;
        r_snap_c0 <= i_req0_counter;
        r_snap_c1 <= i_req1_counter;
      end
      if (w_wait_clr) begin
        r_wait_cnt <= '0;
      end else if (r_state == WAIT0 || r_state == WAIT1) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
      // An absent requester reads as transparent regardless of the ROM.
      if (w_cap0) r_tmp0 <= r_snap_v0 & i_rom_color;
      if (w_cap1) r_tmp1 <= r_snap_v1 & i_rom_color;
      if (w_commit) begin
        o_req0_color <= r_tmp0;
        o_req1_color <= r_tmp1;
        o_color_obs  <= r_tmp0 | r_tmp1;
      end
    end
  end

endmodule

// File: tb/tb_obs_sprite_arbiter.sv
// Self-checking bench: table vectors, hand-written corner sequences and a
// randomized line sweep against a pixel-level reference model.
module tb_obs_sprite_arbiter;
  import dino_pkg::*;

  localparam int unsigned CONV    = 3;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned ROM_LAT = 1;
  localparam int unsigned LAT     = 2 * (ROM_LAT + 1) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [9-CONV:0]   i_hpos;
  logic              i_req0_valid;
  logic [CNT_W-1:0]  i_req0_counter;
  logic              i_req1_valid;
  logic [CNT_W-1:0]  i_req1_counter;
  logic [CNT_W-1:0]  o_rom_counter;
  logic              i_rom_color;
  logic              o_req0_color;
  logic              o_req1_color;
  logic              o_color_obs;
  logic              o_overrun;

  obs_sprite_arbiter #(.CONV(CONV), .ROM_LAT(ROM_LAT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_hpos         (i_hpos),
    .i_req0_valid   (i_req0_valid),
    .i_req0_counter (i_req0_counter),
    .i_req1_valid   (i_req1_valid),
    .i_req1_counter (i_req1_counter),
    .o_rom_counter  (o_rom_counter),
    .i_rom_color    (i_rom_color),
    .o_req0_color   (o_req0_color),
    .o_req1_color   (o_req1_color),
    .o_color_obs    (o_color_obs),
    .o_overrun      (o_overrun)
  );

  always #5 clk = ~clk;

  function automatic logic rom_fn(input logic [CNT_W-1:0] c);
    return c[0] ^ c[2];
  endfunction

  // One-clock-latency sprite ROM.
  always @(posedge clk) i_rom_color <= rom_fn(o_rom_counter);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Pixel-level reference: a snapshot commits LAT edges after its strobe unless
  // another strobe arrives first (including on the commit edge itself).
  logic [9-CONV:0] m_prev = '0;
  logic            m_pend = 1'b0;
  int              m_age  = 0;
  logic            m_s0 = 1'b0, m_s1 = 1'b0;
  logic            m_c0 = 1'b0, m_c1 = 1'b0, m_cobs = 1'b0, m_ovr = 1'b0;

  task automatic step();
    logic st;
    @(posedge clk);
    if (rst) begin
      m_prev = '0; m_pend = 1'b0; m_age = 0;
      m_c0 = 1'b0; m_c1 = 1'b0; m_cobs = 1'b0; m_ovr = 1'b0;
    end else begin
      st     = (i_hpos != m_prev);
      m_prev = i_hpos;
      m_ovr  = st && m_pend;
      if (st) begin
        m_pend = 1'b1;
        m_age  = 0;
        m_s0   = i_req0_valid & rom_fn(i_req0_counter);
        m_s1   = i_req1_valid & rom_fn(i_req1_counter);
      end else if (m_pend) begin
        m_age++;
        if (m_age == int'(LAT)) begin
          m_c0 = m_s0; m_c1 = m_s1; m_cobs = m_s0 | m_s1;
          m_pend = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_req0"},    32'(o_req0_color), 32'(m_c0));
    chk({tag, "_req1"},    32'(o_req1_color), 32'(m_c1));
    chk({tag, "_obs"},     32'(o_color_obs),  32'(m_cobs));
    chk({tag, "_overrun"}, 32'(o_overrun),    32'(m_ovr));
  endtask

  typedef struct {
    logic             v0;
    logic [CNT_W-1:0] c0;
    logic             v1;
    logic [CNT_W-1:0] c1;
    logic             e0;
    logic             e1;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic p0, p1;
    int   novr;
    logic s0, s1, sobs;

    tbl[0] = '{v0:1'b1, c0:3'd1, v1:1'b1, c1:3'd4, e0:1'b1, e1:1'b1};
    tbl[1] = '{v0:1'b0, c0:3'd1, v1:1'b1, c1:3'd5, e0:1'b0, e1:1'b0};
    tbl[2] = '{v0:1'b1, c0:3'd3, v1:1'b0, c1:3'd7, e0:1'b1, e1:1'b0};
    tbl[3] = '{v0:1'b0, c0:3'd6, v1:1'b1, c1:3'd6, e0:1'b0, e1:1'b1};
    tbl[4] = '{v0:1'b1, c0:3'd2, v1:1'b1, c1:3'd7, e0:1'b0, e1:1'b0};
    tbl[5] = '{v0:1'b1, c0:3'd7, v1:1'b1, c1:3'd3, e0:1'b0, e1:1'b1};

    // Reset held 3 clocks with a non-zero hpos.
    rst = 1'b1; i_hpos = 7'd5;
    i_req0_valid = 1'b1; i_req0_counter = 3'd1;
    i_req1_valid = 1'b1; i_req1_counter = 3'd3;
    repeat (3) step();
    chk("rst_req0",  32'(o_req0_color),  32'd0);
    chk("rst_req1",  32'(o_req1_color),  32'd0);
    chk("rst_obs",   32'(o_color_obs),   32'd0);
    chk("rst_ovr",   32'(o_overrun),     32'd0);
    chk("rst_romc",  32'(o_rom_counter), 32'd0);
    chk("rst_state", 32'(dut.r_state),   32'(IDLE));
    rst = 1'b0;
    for (int s = 1; s <= 6; s++) begin
      step();
      if (s == 5) chk("rel_pre_commit", 32'(o_color_obs), 32'd0);
      if (s == 6) begin
        chk("rel_req0", 32'(o_req0_color), 32'd1);
        chk("rel_req1", 32'(o_req1_color), 32'd1);
        chk("rel_obs",  32'(o_color_obs),  32'd1);
      end
    end
    i_hpos = 7'd10;
    repeat (8) step();
    p0 = 1'b1; p1 = 1'b1;

    // Table vectors, one 8-clock pixel each, starting at hpos 11.
    for (int k = 0; k < 6; k++) begin
      i_hpos = 7'(11 + k);
      i_req0_valid = tbl[k].v0; i_req0_counter = tbl[k].c0;
      i_req1_valid = tbl[k].v1; i_req1_counter = tbl[k].c1;
      for (int s = 1; s <= 8; s++) begin
        step();
        chk($sformatf("t%0d_ovr_s%0d", k, s), 32'(o_overrun), 32'd0);
        if (s == 1) chk($sformatf("t%0d_romc0", k), 32'(o_rom_counter),
                        32'(tbl[k].v0 ? tbl[k].c0 : 3'd0));
        if (s == 3) chk($sformatf("t%0d_romc1", k), 32'(o_rom_counter),
                        32'(tbl[k].v1 ? tbl[k].c1 : 3'd0));
        if (s == 5) begin
          chk($sformatf("t%0d_hold0", k), 32'(o_req0_color), 32'(p0));
          chk($sformatf("t%0d_hold1", k), 32'(o_req1_color), 32'(p1));
        end
        if (s == 6) begin
          chk($sformatf("t%0d_req0", k), 32'(o_req0_color), 32'(tbl[k].e0));
          chk($sformatf("t%0d_req1", k), 32'(o_req1_color), 32'(tbl[k].e1));
          chk($sformatf("t%0d_obs", k),  32'(o_color_obs),  32'(tbl[k].e0 | tbl[k].e1));
        end
      end
      p0 = tbl[k].e0; p1 = tbl[k].e1;
    end

    // Counter changes after the strobe must not affect the result.
    i_hpos = 7'd20;
    i_req0_valid = 1'b1; i_req0_counter = 3'd1;
    i_req1_valid = 1'b0; i_req1_counter = 3'd0;
    for (int s = 1; s <= 8; s++) begin
      step();
      if (s == 2) i_req0_counter = 3'd0;
      if (s == 6) begin
        chk("snap_req0", 32'(o_req0_color), 32'd1);
        chk("snap_req1", 32'(o_req1_color), 32'd0);
        chk("snap_obs",  32'(o_color_obs),  32'd1);
      end
      chk_model("snap");
    end

    // Reset in the middle of a sequence.
    i_hpos = 7'd21;
    i_req0_valid = 1'b1; i_req0_counter = 3'd3;
    i_req1_valid = 1'b1; i_req1_counter = 3'd4;
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("mrst_obs",   32'(o_color_obs),   32'd0);
    chk("mrst_romc",  32'(o_rom_counter), 32'd0);
    chk("mrst_state", 32'(dut.r_state),   32'(IDLE));
    rst = 1'b0;
    for (int s = 1; s <= 8; s++) begin
      step();
      chk_model("mrst");
    end
    chk("mrst_commit", 32'(o_color_obs), 32'd1);

    // Pixels every 3 clocks: each strobe after the first aborts the sequence.
    i_req0_valid = 1'b1; i_req0_counter = 3'd2;
    i_req1_valid = 1'b1; i_req1_counter = 3'd5;
    s0 = o_req0_color; s1 = o_req1_color; sobs = o_color_obs;
    novr = 0;
    for (int k = 0; k < 6; k++) begin
      i_hpos = 7'(30 + k);
      for (int s = 0; s < 3; s++) begin
        step();
        if (o_overrun) novr++;
        chk_model("ovr");
        chk("ovr_hold0",   32'(o_req0_color), 32'(s0));
        chk("ovr_hold1",   32'(o_req1_color), 32'(s1));
        chk("ovr_holdobs", 32'(o_color_obs),  32'(sobs));
      end
    end
    chk("ovr_count", 32'(novr), 32'd5);
    for (int s = 0; s < 8; s++) begin
      step();
      chk_model("ovr_resume");
    end
    chk("ovr_resume_obs", 32'(o_color_obs), 32'd0);

    // Randomized full-line sweep with a wrap back to 0.
    novr = 0;
    for (int p = 0; p <= 80; p++) begin
      i_hpos = 7'(p % 80);
      i_req0_valid = 1'($urandom_range(1)); i_req0_counter = 3'($urandom_range(7));
      i_req1_valid = 1'($urandom_range(1)); i_req1_counter = 3'($urandom_range(7));
      for (int s = 0; s < 8; s++) begin
        step();
        if (o_overrun) novr++;
        chk_model($sformatf("sweep_p%0d", p));
      end
    end
    chk("sweep_no_overrun", 32'(novr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
